// File: rtl/tdm_demux1to4.sv
// Serial-to-4-slot TDM demultiplexer: collects four beats into a shadow
// register and presents them as one frame with ready/valid handoff.
module tdm_demux1to4 #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  input  logic       din_valid,
  input  logic       frame_start,
  output logic [3:0] out,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] slot,
  output logic       sync_err,
  output logic       overrun,
  output logic       timeout_err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t     state, state_d;
  logic [1:0] slot_d;
  logic [3:0] shadow, shadow_d;
  logic [7:0] cnt, cnt_d;
  logic [3:0] out_d;
  logic       out_valid_d, sync_err_d, overrun_d, timeout_err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      slot        <= '0;
      shadow      <= '0;
      cnt         <= '0;
      out         <= '0;
      out_valid   <= 1'b0;
      sync_err    <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      slot        <= slot_d;
      shadow      <= shadow_d;
      cnt         <= cnt_d;
      out         <= out_d;
      out_valid   <= out_valid_d;
      sync_err    <= sync_err_d;
      overrun     <= overrun_d;
      timeout_err <= timeout_err_d;
    end
  end

  always_comb begin
    state_d       = state;
    slot_d        = slot;
    shadow_d      = shadow;
    cnt_d         = cnt;
    out_d         = out;
    out_valid_d   = out_valid;
    sync_err_d    = 1'b0;
    overrun_d     = 1'b0;
    timeout_err_d = 1'b0;

    // Acceptance clears valid unless a completing frame re-sets it below.
    if (out_valid && out_ready) out_valid_d = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_d = '0;
        if (din_valid && frame_start) begin
          shadow_d = {3'b000, din};
          slot_d   = 2'd1;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (din_valid) begin
          cnt_d = '0;
          if (frame_start) begin
            sync_err_d = (slot != 2'd0);
            shadow_d   = {3'b000, din};
            slot_d     = 2'd1;
          end else if (slot == 2'd3) begin
            out_d       = {din, shadow[2:0]};
            out_valid_d = 1'b1;
            overrun_d   = out_valid && !out_ready;
            shadow_d    = '0;
            slot_d      = 2'd0;
            state_d     = IDLE;
          end else begin
            shadow_d[slot] = din;
            slot_d         = slot + 2'd1;
          end
        end else if (cnt == 8'(TIMEOUT - 1)) begin
          timeout_err_d = 1'b1;
          shadow_d      = '0;
          cnt_d         = '0;
          slot_d        = 2'd0;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/tdm_demux1to4.md
TDM_DEMUX1TO4 -- requirements
Module: tdm_demux1to4

Interface
REQ-001 Parameter TIMEOUT, default 16: number of consecutive cycles without din_valid in RUN after which the frame is abandoned (legal range 2..255).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 din  input  1  serial time-multiplexed data bit.
REQ-005 din_valid  input  1  din is meaningful this cycle.
REQ-006 frame_start  input  1  qualifies din as slot 0 when din_valid=1; ignored when din_valid=0.
REQ-007 out  output  4  demultiplexed frame; out[k] holds the slot-k bit.
REQ-008 out_valid  output  1  out holds an unconsumed frame.
REQ-009 out_ready  input  1  consumer accepts out when out_valid=1.
REQ-010 slot  output  2  slot index the next accepted bit will occupy (mirror of a 4:1 mux select).
REQ-011 sync_err  output  1  one-cycle pulse: frame_start arrived mid-frame.
REQ-012 overrun  output  1  one-cycle pulse: completed frame overwrote an unconsumed frame.
REQ-013 timeout_err  output  1  one-cycle pulse: partial frame abandoned by TIMEOUT.

Function
REQ-014 States SHALL be IDLE and RUN; the reset state is IDLE.
REQ-015 In IDLE, a beat (din_valid=1) without frame_start SHALL be discarded; a beat with frame_start SHALL write din to shadow bit 0, set slot=1 and enter RUN.
REQ-016 In RUN, a beat without frame_start SHALL write din to shadow bit [slot] and increment slot modulo 4.
REQ-017 A beat on slot 3 SHALL complete the frame: the next cycle out = {din, shadow[2:0]}, out_valid=1, slot=0, and the state returns to IDLE.
REQ-018 Latency SHALL be one cycle from the slot-3 beat to out/out_valid update.
REQ-019 In RUN with slot≠0, a beat with frame_start SHALL pulse sync_err the next cycle, discard the partial frame, and treat the beat as slot 0 of a new frame (shadow bit 0=din, slot=1).
REQ-020 out_valid SHALL hold, with out stable, until a cycle with out_valid=1 and out_ready=1, after which it clears the next cycle unless a new frame completes in that same cycle.
REQ-021 Frame completion and acceptance in the same cycle SHALL leave out_valid=1 with the new frame on out and no overrun.
REQ-022 Frame completion while out_valid=1 and out_ready=0 SHALL overwrite out, keep out_valid=1, and pulse overrun.
REQ-023 The idle counter SHALL clear on every beat; in RUN it SHALL increment on each non-beat cycle, and on reaching TIMEOUT the block SHALL pulse timeout_err, discard the partial frame, set slot=0 and enter IDLE.
REQ-024 The idle counter SHALL be held at 0 in IDLE, and the timeout SHALL never affect out or out_valid.
REQ-025 The pulse outputs SHALL be registered, each high for exactly one cycle per event; simultaneous events SHALL each pulse independently.

Reset
REQ-026 rst=1 SHALL immediately force state=IDLE, slot=0, out=4'b0000, out_valid=0, sync_err=0, overrun=0, timeout_err=0, shadow=0, and idle counter=0, regardless of clk.
REQ-027 Deasserting rst SHALL take effect at the next rising edge, and a frame interrupted by reset SHALL be lost, never delivered.

Verification
REQ-028 Beats 1,0,1,1 on consecutive cycles, frame_start with the first, out_ready=1 -> out=4'b1101, out_valid high for one cycle, one cycle after the fourth beat.
REQ-029 Two back-to-back frames 1101 then 0010 with out_ready=0 -> out=4'b0010, out_valid=1, and an overrun pulse when the second frame lands.
REQ-030 Beats on slots 0,1, then a frame_start beat -> sync_err pulse, slot=1, and the following three beats complete a frame from the new start.
REQ-031 Beats on slots 0,1, then 16 idle cycles (TIMEOUT=16) -> timeout_err pulse, slot=0, IDLE; a later beat without frame_start is ignored.
REQ-032 Assert rst asynchronously after the slot-2 beat of a frame -> all outputs reach reset values before the next clk edge, and no out_valid follows.
REQ-033 Four beats without frame_start from IDLE -> slot stays 0 and out_valid stays 0.
